// File: rtl/sha256_msg_sched_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched_if
// Handshake bundle for the SHA-256 message-schedule generator.
//   in_valid_i / in_data_i / in_ready_o  : 32-bit load words, W[0] first
//   out_valid_o / out_data_o / out_idx_o / out_last_o / out_ready_i
//                                        : expanded schedule words W[0..63]
//   busy_o                               : block in progress
// The slave modport is the schedule generator; master is its partner.
// ---------------------------------------------------------------------------
interface sha256_msg_sched_if;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [5:0]  out_idx_o;
    logic        out_last_o;
    logic        out_ready_i;
    logic        busy_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// Streaming SHA-256 message-schedule generator. Loads one 512-bit block as
// 16 x 32-bit words, then emits W[0..63] one word per handshake, expanding
// W[16..63] in place inside a 16-entry circular buffer.
// Ports:
//   clk      : rising-edge clock
//   n_reset  : asynchronous active-low reset (LOAD, cnt = 0, buffer cleared)
//   abort_i  : synchronous abandon of the current block (buffer kept)
//   bus      : sha256_msg_sched_if.slave load/emit handshakes and busy flag
// Build option:
//   MSG_SCHED_STREAM_EN : pass W[0..15] straight through while loading and
//                         start emitting at t = 16 (combinational valid/ready).
// ---------------------------------------------------------------------------
module sha256_msg_sched (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               abort_i,
    sha256_msg_sched_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

`ifdef MSG_SCHED_STREAM_EN
    localparam logic [5:0] EMIT_START = 6'd16;
`else
    localparam logic [5:0] EMIT_START = 6'd0;
`endif

    // Small sigma functions, bit-identical to the core's SMS0/SMS1.
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 5'd3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 5'd10);
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_nx_s;
    logic [31:0] sched_buf_r [16];

    logic        buf_we_s;
    logic [31:0] buf_wdata_s;
    logic [3:0]  idx_m2_s;
    logic [3:0]  idx_m7_s;
    logic [3:0]  idx_m15_s;
    logic [31:0] sched_word_s;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [5:0]  out_idx_s;
    logic        out_last_s;
    logic        in_hs_s;
    logic        out_hs_s;

    // Expansion of W[t] from the window; W[t-16] sits in the slot being replaced.
    always_comb begin
        idx_m2_s     = cnt_r[3:0] - 4'd2;
        idx_m7_s     = cnt_r[3:0] - 4'd7;
        idx_m15_s    = cnt_r[3:0] - 4'd15;
        sched_word_s = sig1(sched_buf_r[idx_m2_s]) + sched_buf_r[idx_m7_s]
                     + sig0(sched_buf_r[idx_m15_s]) + sched_buf_r[cnt_r[3:0]];
    end

    // Handshake-side outputs; data/idx/last are forced to zero when not valid.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_data_s  = 32'd0;
        out_idx_s   = 6'd0;
        out_last_s  = 1'b0;
        case (state_r)
            ST_LOAD: begin
`ifdef MSG_SCHED_STREAM_EN
                in_ready_s  = bus.out_ready_i;
                out_valid_s = bus.in_valid_i;
                if (bus.in_valid_i) begin
                    out_data_s = bus.in_data_i;
                    out_idx_s  = cnt_r;
                end else begin
                    out_data_s = 32'd0;
                    out_idx_s  = 6'd0;
                end
`else
                in_ready_s  = 1'b1;
`endif
            end
            ST_EMIT: begin
                out_valid_s = 1'b1;
                out_idx_s   = cnt_r;
                out_last_s  = (cnt_r == 6'd63);
                if (cnt_r < 6'd16) begin
                    out_data_s = sched_buf_r[cnt_r[3:0]];
                end else begin
                    out_data_s = sched_word_s;
                end
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign in_hs_s  = bus.in_valid_i & in_ready_s;
    assign out_hs_s = out_valid_s & bus.out_ready_i;

    // Next-state, counter and buffer-write decode; abort overrides any handshake.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        buf_we_s    = 1'b0;
        buf_wdata_s = 32'd0;
        if (abort_i) begin
            state_nx_s = ST_LOAD;
            cnt_nx_s   = 6'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (in_hs_s) begin
                        buf_we_s    = 1'b1;
                        buf_wdata_s = bus.in_data_i;
                        if (cnt_r == 6'd15) begin
                            state_nx_s = ST_EMIT;
                            cnt_nx_s   = EMIT_START;
                        end else begin
                            cnt_nx_s   = cnt_r + 6'd1;
                        end
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
                ST_EMIT: begin
                    if (out_hs_s) begin
                        if (cnt_r >= 6'd16) begin
                            buf_we_s    = 1'b1;
                            buf_wdata_s = sched_word_s;
                        end else begin
                            buf_we_s    = 1'b0;
                        end
                        if (cnt_r == 6'd63) begin
                            state_nx_s = ST_LOAD;
                            cnt_nx_s   = 6'd0;
                        end else begin
                            cnt_nx_s   = cnt_r + 6'd1;
                        end
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
                default: begin
                    state_nx_s = ST_LOAD;
                    cnt_nx_s   = 6'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_LOAD;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Circular window buffer; the write slot is always cnt[3:0].
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 16; i++) begin
                sched_buf_r[i] <= 32'd0;
            end
        end else if (buf_we_s) begin
            sched_buf_r[cnt_r[3:0]] <= buf_wdata_s;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = out_valid_s;
    assign bus.out_data_o  = out_data_s;
    assign bus.out_idx_o   = out_idx_s;
    assign bus.out_last_o  = out_last_s;
    assign bus.busy_o      = (state_r != ST_LOAD) || (cnt_r != 6'd0);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_sched
// Randomized scoreboard bench: each loaded block pushes its 64 expected
// schedule words (from a plain-array reference model) into a queue; a
// monitor pops and compares on every out handshake.
// ---------------------------------------------------------------------------
module tb_sha256_msg_sched;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];
    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
    } exp_t;

    logic clk;
    logic n_reset;
    logic abort_i;

    sha256_msg_sched_if ifc();

    sha256_msg_sched dut (
        .clk     (clk),
        .n_reset (n_reset),
        .abort_i (abort_i),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    logic [31:0] cap [64];

    // Reference model: the schedule recurrence over a full 64-entry array.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void model(input blk_t b, output sched_t w);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = b[t];
            end else begin
                w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
                     + w[t-7]
                     + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                     + w[t-16];
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Consumer ready: always high or pseudo-random, changed just after each edge.
    initial begin
        ifc.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifc.out_ready_i = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scoreboard pops, stall stability, and LOAD re-entry after t = 63.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = 32'd0;
        logic [5:0]  prev_idx   = 6'd0;
        logic        post_last  = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                prev_stall = 1'b0;
                post_last  = 1'b0;
            end else begin
                if (post_last) begin
`ifdef MSG_SCHED_STREAM_EN
                    check("ready_after_last", ifc.in_ready_o, ifc.out_ready_i);
`else
                    check("ready_after_last", ifc.in_ready_o, 1);
`endif
                    check("busy_after_last", ifc.busy_o, 0);
                    post_last = 1'b0;
                end
                if (prev_stall) begin
                    check("stall_data", ifc.out_data_o, prev_data);
                    check("stall_idx", ifc.out_idx_o, prev_idx);
                end
                if (ifc.out_valid_o && ifc.out_ready_i && !abort_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got idx %0d, none expected", ifc.out_idx_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_idx", ifc.out_idx_o, e.idx);
                        check("out_data", ifc.out_data_o, e.data);
                        check("out_last", ifc.out_last_o, (e.idx == 6'd63));
                        cap[e.idx] = ifc.out_data_o;
                        if (e.idx == 6'd63) post_last = 1'b1;
                    end
                end
                prev_stall = ifc.out_valid_o && !ifc.out_ready_i && !abort_i;
                prev_data  = ifc.out_data_o;
                prev_idx   = ifc.out_idx_o;
            end
        end
    end

    // Push the block's schedule, then load the first nwords words (optional gaps).
    task automatic load_block(input blk_t blk, input bit gaps, input int nwords);
        sched_t w;
        exp_t   e;
        bit     hs;
        int     n;
        model(blk, w);
        for (int t = 0; t < 64; t++) begin
            e.data = w[t];
            e.idx  = 6'(t);
            exp_q.push_back(e);
        end
        for (int i = 0; i < nwords; i++) begin
            if (gaps) begin
                n = 0;
                while ($urandom_range(0, 2) == 0 && n < 4) begin
                    ifc.in_valid_i = 1'b0;
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
            ifc.in_valid_i = 1'b1;
            ifc.in_data_i  = blk[i];
            n = 0;
            do begin
                @(negedge clk);
                hs = ifc.in_ready_o;
                @(posedge clk);
                #1;
                n++;
            end while (!hs && n < 1000);
            if (!hs) check("load_timeout", 0, 1);
        end
        ifc.in_valid_i = 1'b0;
        ifc.in_data_i  = 32'd0;
        if (nwords == 16) check("first_out_valid", ifc.out_valid_o, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        blk_t abc;
        blk_t ones;
        blk_t rnd;
        int   n;
        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'd0;
            ones[i] = 32'hFFFF_FFFF;
        end
        abc[0]  = 32'h6162_6380;
        abc[15] = 32'h0000_0018;

        n_reset        = 1'b0;
        abort_i        = 1'b0;
        ifc.in_valid_i = 1'b0;
        ifc.in_data_i  = 32'd0;
        #12;
        check("rst_in_ready", ifc.in_ready_o, 1);
        check("rst_out_valid", ifc.out_valid_o, 0);
        check("rst_busy", ifc.busy_o, 0);
        check("rst_out_data", ifc.out_data_o, 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // "abc" with an always-ready consumer.
        rdy_mode = 0;
        load_block(abc, 1'b0, 16);
        drain();
        check("abc_w16", cap[16], 32'h6162_6380);
        check("abc_w17", cap[17], 32'h000F_0000);
        check("abc_w63", cap[63], 32'h12B1_EDEB);

        // Same block with a stalling consumer and gappy producer.
        rdy_mode = 1;
        load_block(abc, 1'b1, 16);
        drain();
        check("abc_stall_w63", cap[63], 32'h12B1_EDEB);

        // Abort when idx 30 is presented with ready high.
        rdy_mode = 0;
        load_block(abc, 1'b0, 16);
        n = 0;
        while (!(ifc.out_valid_o && ifc.out_idx_o == 6'd30) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach_idx30", ifc.out_idx_o, 30);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        exp_q.delete();
        check("abort_out_valid", ifc.out_valid_o, 0);
        check("abort_busy", ifc.busy_o, 0);
        check("abort_in_ready", ifc.in_ready_o, 1);
        cap[17] = 32'd0;
        load_block(abc, 1'b0, 16);
        drain();
        check("abort_reload_w17", cap[17], 32'h000F_0000);

        // Asynchronous reset after 7 load words.
        load_block(abc, 1'b0, 7);
        check("midload_busy", ifc.busy_o, 1);
        #2;
        n_reset = 1'b0;
        #1;
        check("arst_out_valid", ifc.out_valid_o, 0);
        check("arst_in_ready", ifc.in_ready_o, 1);
        check("arst_busy", ifc.busy_o, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        cap[63] = 32'd0;
        load_block(abc, 1'b0, 16);
        drain();
        check("arst_reload_w63", cap[63], 32'h12B1_EDEB);

        // All-ones block exercises the 32-bit wrap of the sum.
        rdy_mode = 1;
        load_block(ones, 1'b1, 16);
        drain();

        // Random blocks.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            load_block(rnd, 1'b1, 16);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
